// File: rtl/line_wr_burst_pkg.sv
// Shared definitions for the cache line write-back burst engine:
// FSM states, AXI3 encodings and line/beat arithmetic.
package line_wr_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_e;

    localparam int         WORD_BITS      = 32;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_STRB_ALL   = 4'hF;

    function automatic int lineBeats(input int lineWidth);
        return lineWidth / WORD_BITS;
    endfunction

    // A single-beat line still needs a one-bit counter to stay legal.
    function automatic int beatCntWidth(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/line_wr_burst_if.sv
// AXI3 write-channel bundle (AW, W, B) between the burst master and a slave.
interface line_wr_burst_if #(
    parameter int BUS_WIDTH = 4
);
    logic [BUS_WIDTH-1:0] awid;
    logic [31:0]          awaddr;
    logic [3:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;

    logic [BUS_WIDTH-1:0] wid;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [BUS_WIDTH-1:0] bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/line_wr_burst.sv
// Writes one evicted cache line to memory as a single AXI3 INCR burst of
// 32-bit beats, then reports completion (and slave error) with a done pulse.
module line_wr_burst
    import line_wr_burst_pkg::*;
#(
    parameter int  LINE_WIDTH       = 256,
    parameter int  AWID             = 2,
    parameter int  BUS_WIDTH        = 4,
    localparam int BEATS            = lineBeats(LINE_WIDTH),
    localparam int BURST_LIMIT      = BEATS - 1,
    localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
    localparam int LABEL_WIDTH      = 32 - LINE_BYTE_OFFSET
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   line_vld_i,
    input  logic [LABEL_WIDTH-1:0] line_label_i,
    input  logic [LINE_WIDTH-1:0]  line_data_i,
    output logic                   line_rdy_o,
    output logic                   done_o,
    output logic                   err_o,
    line_wr_burst_if.master        axi
);

    localparam int CNT_W = beatCntWidth(BEATS);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LABEL_WIDTH-1:0] label_q, label_d;
    logic [LINE_WIDTH-1:0]  data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   lastBeat;

    assign lastBeat = (cnt_q == CNT_W'(BURST_LIMIT));

    // Payload fields depend only on latched state, so they stay stable under stalls.
    assign axi.awid    = BUS_WIDTH'(AWID);
    assign axi.awaddr  = {label_q, {LINE_BYTE_OFFSET{1'b0}}};
    assign axi.awlen   = 4'(BURST_LIMIT);
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wid     = BUS_WIDTH'(AWID);
    assign axi.wdata   = data_q[int'(cnt_q)*WORD_BITS +: WORD_BITS];
    assign axi.wstrb   = AXI_STRB_ALL;
    assign done_o      = done_q;
    assign err_o       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            label_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            label_q <= label_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        label_d     = label_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        line_rdy_o  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                line_rdy_o = 1'b1;
                if (line_vld_i) begin
                    label_d = line_label_i;
                    data_d  = line_data_i;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                axi.wvalid = 1'b1;
                axi.wlast  = lastBeat;
                if (axi.wready) begin
                    if (lastBeat) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    done_d  = 1'b1;
                    err_d   = (axi.bresp != AXI_RESP_OKAY);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_wr_burst.sv
// Directed and randomized bench for line_wr_burst: a slave driven cycle by cycle
// and a line-level model of the expected AXI3 burst and completion pulse.
module tb_line_wr_burst;

    localparam int LINE_WIDTH = 256;
    localparam int LABEL_W    = 27;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic                  lineVld;
    logic [LABEL_W-1:0]    lineLabel;
    logic [LINE_WIDTH-1:0] lineData;
    logic                  lineRdy;
    logic                  done;
    logic                  err;

    int assertCount = 0;
    int failCount   = 0;

    line_wr_burst_if #(.BUS_WIDTH(4)) axi ();

    line_wr_burst #(
        .LINE_WIDTH(LINE_WIDTH),
        .AWID      (2),
        .BUS_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .line_vld_i  (lineVld),
        .line_label_i(lineLabel),
        .line_data_i (lineData),
        .line_rdy_o  (lineRdy),
        .done_o      (done),
        .err_o       (err),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [LINE_WIDTH-1:0] randomLine();
        logic [LINE_WIDTH-1:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // One line, from offer to done pulse. Returns at the negedge of the done cycle
    // (or after abortBeats beats have been taken) without advancing the clock.
    task automatic applyStimulus(input logic [LABEL_W-1:0] lbl, input logic [LINE_WIDTH-1:0] dat,
                                 input int awDelay, input int wMode, input logic [1:0] bresp,
                                 input int abortBeats, input bit carryDone, input bit carryErr,
                                 input bit nxtVld, input logic [LABEL_W-1:0] nxtLbl,
                                 input logic [LINE_WIDTH-1:0] nxtDat);
        logic [31:0] words [8];
        int  cyc = 0, acceptCyc = -1, beat = 0, awSeen = 0, wSeen = 0;
        bit  accepted = 0, awHs = 0, respHs = 0, finished = 0;
        bit  expDone = carryDone, expErr = carryErr, expAw, expW, expB;
        for (int i = 0; i < 8; i++) words[i] = dat[32*i +: 32];
        lineVld = 1'b1; lineLabel = lbl; lineData = dat;
        while (!finished && cyc < 400) begin
            axi.awready = (awSeen >= awDelay);
            case (wMode)
                0:       axi.wready = 1'b1;
                1:       axi.wready = (wSeen % 2 == 0);
                default: axi.wready = 1'($urandom_range(0, 1));
            endcase
            axi.bresp = bresp; axi.bvalid = 1'b1; axi.bid = 4'($urandom);
            #1;
            expAw = accepted && !awHs;
            expW  = awHs && beat < 8;
            expB  = beat == 8 && !respHs;
            checkOutput("done", done, expDone);
            checkOutput("err", err, expErr);
            checkOutput("lineRdy", lineRdy, !accepted || respHs);
            checkOutput("awvalid", axi.awvalid, expAw);
            checkOutput("wvalid", axi.wvalid, expW);
            checkOutput("bready", axi.bready, expB);
            if (expAw) begin
                checkOutput("awaddr", axi.awaddr, {lbl, 5'b0});
                checkOutput("awlen", axi.awlen, 7);
                checkOutput("awsize", axi.awsize, 3'b010);
                checkOutput("awburst", axi.awburst, 2'b01);
                checkOutput("awid", axi.awid, 2);
            end
            if (expW) begin
                checkOutput("wdata", axi.wdata, words[beat]);
                checkOutput("wlast", axi.wlast, beat == 7);
                checkOutput("wstrb", axi.wstrb, 4'hF);
                checkOutput("wid", axi.wid, 2);
            end else begin
                checkOutput("wlastIdle", axi.wlast, 0);
            end
            if (respHs && done) begin
                finished = 1;
                checkOutput("beatCount", beat, 8);
                if (awDelay == 0 && wMode == 0) checkOutput("latency", cyc - acceptCyc, 11);
            end else begin
                if (expAw) begin awSeen++; if (axi.awready) awHs = 1; end
                if (expW) begin wSeen++; if (axi.wready) beat++; end
                if (expB) respHs = 1;
                expDone = expB;
                expErr  = expB && (bresp != 2'b00);
                if (!accepted && lineVld) begin accepted = 1; acceptCyc = cyc; end
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (acceptCyc == cyc - 1) begin
                    lineVld = nxtVld; lineLabel = nxtLbl; lineData = nxtDat;
                end
                if (abortBeats >= 0 && beat == abortBeats) finished = 1;
            end
        end
        if (!finished) checkOutput("timeout", 1, 0);
    endtask

    task automatic idleCheck();
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("donePulseEnd", done, 0);
        checkOutput("errPulseEnd", err, 0);
        checkOutput("lineRdyAfter", lineRdy, 1);
    endtask

    initial begin
        logic [LINE_WIDTH-1:0] dA, dB;
        logic [LABEL_W-1:0]    lA, lB;
        logic [1:0]            rsp;

        rstN = 1'b0; lineVld = 1'b0; lineLabel = '0; lineData = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstLineRdy", lineRdy, 1);
        checkOutput("rstAwvalid", axi.awvalid, 0);
        checkOutput("rstWvalid", axi.wvalid, 0);
        checkOutput("rstWlast", axi.wlast, 0);
        checkOutput("rstBready", axi.bready, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", err, 0);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] directed line, zero-wait slave");
        for (int i = 0; i < 8; i++) dA[32*i +: 32] = i;
        applyStimulus(27'h0000123, dA, 0, 0, 2'b00, -1, 0, 0, 0, '0, '0);
        idleCheck();

        $display("[TB] awready held low for 5 cycles");
        applyStimulus(27'($urandom), randomLine(), 5, 0, 2'b00, -1, 0, 0, 0, '0, '0);
        idleCheck();

        $display("[TB] wready toggling");
        applyStimulus(27'($urandom), randomLine(), 0, 1, 2'b00, -1, 0, 0, 0, '0, '0);
        idleCheck();

        $display("[TB] slave error response");
        applyStimulus(27'($urandom), randomLine(), 0, 0, 2'b10, -1, 0, 0, 0, '0, '0);
        idleCheck();

        $display("[TB] reset in the middle of a burst");
        applyStimulus(27'($urandom), randomLine(), 0, 0, 2'b00, 4, 0, 0, 0, '0, '0);
        #1;
        checkOutput("preRstWvalid", axi.wvalid, 1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("abortAwvalid", axi.awvalid, 0);
        checkOutput("abortWvalid", axi.wvalid, 0);
        checkOutput("abortBready", axi.bready, 0);
        checkOutput("abortLineRdy", lineRdy, 1);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        applyStimulus(27'($urandom), randomLine(), 0, 0, 2'b00, -1, 0, 0, 0, '0, '0);
        idleCheck();

        $display("[TB] back-to-back lines");
        lA = 27'($urandom); lB = 27'($urandom); dA = randomLine(); dB = randomLine();
        applyStimulus(lA, dA, 0, 0, 2'b00, -1, 0, 0, 1, lB, dB);
        applyStimulus(lB, dB, 1, 2, 2'b00, -1, 1, 0, 0, '0, '0);
        idleCheck();

        $display("[TB] randomized lines");
        for (int n = 0; n < 6; n++) begin
            rsp = 2'($urandom);
            applyStimulus(27'($urandom), randomLine(), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), rsp, -1, 0, 0, 0, '0, '0);
            idleCheck();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/line_wr_burst.md
LINE_WR_BURST -- requirements
Module: line_wr_burst

Interface
REQ-001 Parameter LINE_WIDTH, default 256, cache line width in bits; a multiple of 32.
REQ-002 Parameter AWID, default 2, constant AXI3 ID driven on awid and wid.
REQ-003 Parameter BUS_WIDTH, default 4, width of the AXI3 ID fields.
REQ-004 Derived constants: BEATS = LINE_WIDTH/32; BURST_LIMIT = BEATS-1; LINE_BYTE_OFFSET = clog2(LINE_WIDTH/8); LABEL_WIDTH = 32-LINE_BYTE_OFFSET.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 line_vld  in  1  upstream write buffer offers an evicted line.
REQ-008 line_label  in  LABEL_WIDTH  physical line address above LINE_BYTE_OFFSET.
REQ-009 line_data  in  LINE_WIDTH  line payload; word 0 in bits [31:0].
REQ-010 line_rdy  out  1  line accepted this cycle when line_vld & line_rdy.
REQ-011 done  out  1  one-cycle pulse when the burst's B response is taken.
REQ-012 err  out  1  qualifies done; 1 when bresp != OKAY.
REQ-013 awid/awaddr/awlen/awsize/awburst  out  BUS_WIDTH/32/4/3/2  AXI3 AW payload.
REQ-014 awvalid out 1, awready in 1  AW handshake.
REQ-015 wid/wdata/wstrb/wlast  out  BUS_WIDTH/32/4/1  AXI3 W payload.
REQ-016 wvalid out 1, wready in 1  W handshake.
REQ-017 bid in BUS_WIDTH, bresp in 2, bvalid in 1, bready out 1  AXI3 B channel.

Function
REQ-018 FSM states IDLE, ADDR, DATA, RESP; one line in flight at a time.
REQ-019 line_rdy SHALL be 1 only in IDLE; line_vld & line_rdy latches label and data, enters ADDR.
REQ-020 ADDR: awvalid=1, awaddr={label, LINE_BYTE_OFFSET zeros}, awlen=BURST_LIMIT, awsize=3'b010, awburst=2'b01 (INCR), awid=AWID; payload stable until awready; awvalid&awready -> DATA.
REQ-021 DATA: wvalid=1, wdata=latched data[32*cnt +: 32], wstrb=4'hF, wid=AWID, wlast=(cnt==BURST_LIMIT); cnt increments on wvalid&wready.
REQ-022 Beat counter width clog2(BEATS); cleared on entry to DATA; no wrap beyond BURST_LIMIT.
REQ-023 Last beat handshake -> RESP, cnt cleared.
REQ-024 RESP: bready=1; bvalid -> done=1 next cycle with err=(bresp!=2'b00); return to IDLE same edge.
REQ-025 done and err SHALL be registered; err holds its value only while done=1, otherwise 0.
REQ-026 Zero-wait slave (awready, wready, bvalid always 1): line accept to done = 1 + 1 + BEATS + 1 cycles (11 for 256-bit).
REQ-027 wvalid deasserted by slave stall never occurs; the master holds wvalid=1 throughout DATA (no bubbles).
REQ-028 Back-to-back lines: the next line is accepted in the cycle after RESP completes (line_rdy=1 in IDLE).
REQ-029 bid is ignored; mismatched bid SHALL NOT alter behaviour.

Reset
REQ-030 rst_n low SHALL force IDLE asynchronously, mid-burst included, abandoning any in-flight transaction.
REQ-031 Reset values: awvalid=0, wvalid=0, wlast=0, bready=0, done=0, err=0, line_rdy=1 after release, counter=0.

Structure
REQ-032 BEATS-related constants, the state enum and the AXI burst/size encodings SHALL live in the shared cache package.
REQ-033 Single module, no sub-module; latched line held in one LINE_WIDTH register.

Verification
REQ-034 Zero-wait slave, label 27'h0000123, data words 0..7 = 32'h0..32'h7 -> awaddr 32'h00002460, awlen 7, beats 0..7 in order, wlast only on beat 7, done 11 cycles after accept, err=0.
REQ-035 awready held low 5 cycles -> AW payload stable throughout, no wvalid before AW handshake.
REQ-036 wready toggling 1,0,1,0 -> each word sent exactly once, wdata stable while stalled, 8 handshakes total.
REQ-037 bresp=2'b10 (SLVERR) -> done=1 with err=1 for exactly one cycle, line_rdy=1 the cycle after.
REQ-038 rst_n asserted after beat 3 -> awvalid/wvalid/bready drop immediately, next line restarts at beat 0.
REQ-039 Two lines offered back-to-back -> second line_rdy only after first done; both bursts complete in order.
